// File: rtl/sprite_draw_sched.sv
// Two-requester sprite box scheduler: round-robin grants the VGA write port,
// erases the requester's previous 4x4 box (if any) and plots the new one.
module sprite_draw_sched #(
  parameter int          BOX       = 4,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic [7:0] req0_x,
  input  logic [7:0] req1_x,
  input  logic [6:0] req0_y,
  input  logic [6:0] req1_y,
  input  logic [2:0] req0_colour,
  input  logic [2:0] req1_colour,
  output logic [1:0] grant,
  output logic       done,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       writeEn
);

  localparam logic [3:0] CNT_LAST = 4'(BOX * BOX - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ERASE, S_PLOT, S_DONE} state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_ptr;
  logic       r_gidx;
  logic [1:0] r_grant;
  logic       r_done;
  logic       r_busy;
  logic       r_we;
  logic [7:0] r_vx;
  logic [6:0] r_vy;
  logic [2:0] r_vc;
  logic [1:0] r_valid;

  logic [7:0] r_nx;
  logic [6:0] r_ny;
  logic [2:0] r_col;
  logic [7:0] r_old_x [2];
  logic [6:0] r_old_y [2];

  logic       w_win;
  logic [7:0] w_sel_x;
  logic [6:0] w_sel_y;
  logic [2:0] w_sel_col;
  logic [7:0] w_old_x;
  logic [6:0] w_old_y;
  logic [3:0] w_cnt_inc;
  logic [7:0] w_off_x;
  logic [6:0] w_off_y;

  // Contention goes to the pointer; a lone requester always wins.
  assign w_win     = (req == 2'b11) ? r_ptr : req[1];
  assign w_sel_x   = r_gidx ? req1_x : req0_x;
  assign w_sel_y   = r_gidx ? req1_y : req0_y;
  assign w_sel_col = r_gidx ? req1_colour : req0_colour;
  assign w_old_x   = r_old_x[r_gidx];
  assign w_old_y   = r_old_y[r_gidx];
  assign w_cnt_inc = r_cnt + 4'd1;
  assign w_off_x   = {6'b0, w_cnt_inc[1:0]};
  assign w_off_y   = {5'b0, w_cnt_inc[3:2]};

  // Output registers hold the pixel for the current cycle, so each branch
  // loads the address of the pixel that will be written next cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_ptr   <= 1'b0;
      r_gidx  <= 1'b0;
      r_grant <= 2'b00;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_we    <= 1'b0;
      r_vx    <= 8'd0;
      r_vy    <= 7'd0;
      r_vc    <= 3'd0;
      r_valid <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req != 2'b00) begin
            r_gidx  <= w_win;
            r_grant <= w_win ? 2'b10 : 2'b01;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= 4'd0;
          r_we  <= 1'b1;
          if (r_valid[r_gidx]) begin
            r_vx    <= w_old_x;
            r_vy    <= w_old_y;
            r_vc    <= BG_COLOUR;
            r_state <= S_ERASE;
          end else begin
            r_vx    <= w_sel_x;
            r_vy    <= w_sel_y;
            r_vc    <= w_sel_col;
            r_state <= S_PLOT;
          end
        end
        S_ERASE: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= 4'd0;
            r_vx    <= r_nx;
            r_vy    <= r_ny;
            r_vc    <= r_col;
            r_state <= S_PLOT;
          end else begin
            r_cnt <= w_cnt_inc;
            r_vx  <= w_old_x + w_off_x;
            r_vy  <= w_old_y + w_off_y;
          end
        end
        S_PLOT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_vx    <= 8'd0;
            r_vy    <= 7'd0;
            r_vc    <= 3'd0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_inc;
            r_vx  <= r_nx + w_off_x;
            r_vy  <= r_ny + w_off_y;
          end
        end
        S_DONE: begin
          r_done          <= 1'b0;
          r_busy          <= 1'b0;
          r_grant         <= 2'b00;
          r_valid[r_gidx] <= 1'b1;
          r_ptr           <= ~r_ptr;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Box data needs no reset: the valid flags gate every use of it.
  always_ff @(posedge clock) begin
    if (r_state == S_LOAD) begin
      r_nx  <= w_sel_x;
      r_ny  <= w_sel_y;
      r_col <= w_sel_col;
    end
    if (r_state == S_DONE) begin
      r_old_x[r_gidx] <= r_nx;
      r_old_y[r_gidx] <= r_ny;
    end
  end

  assign grant      = r_grant;
  assign done       = r_done;
  assign busy       = r_busy;
  assign writeEn    = r_we;
  assign vga_x      = r_vx;
  assign vga_y      = r_vy;
  assign vga_colour = r_vc;

endmodule

// File: tb/tb_sprite_draw_sched.sv
// Directed bench for sprite_draw_sched: walks through each service scenario
// and checks grants, every pixel write, done timing and reset behaviour.
module tb_sprite_draw_sched;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] req0_x = 8'd0, req1_x = 8'd0;
  logic [6:0] req0_y = 7'd0, req1_y = 7'd0;
  logic [2:0] req0_colour = 3'd0, req1_colour = 3'd0;
  logic [1:0] grant;
  logic       done, busy, writeEn;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int total = 0;
  int bad = 0;

  sprite_draw_sched #(.BOX(4), .BG_COLOUR(3'b000)) dut (
    .clock(clock), .resetn(resetn), .req(req),
    .req0_x(req0_x), .req1_x(req1_x), .req0_y(req0_y), .req1_y(req1_y),
    .req0_colour(req0_colour), .req1_colour(req1_colour),
    .grant(grant), .done(done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .writeEn(writeEn)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_we"}, 32'(writeEn), 0);
    chk({tag, "_x"}, 32'(vga_x), 0);
    chk({tag, "_y"}, 32'(vga_y), 0);
    chk({tag, "_col"}, 32'(vga_colour), 0);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req = 2'b00;
    repeat (3) @(negedge clock);
    check_quiet("reset");
    resetn = 1'b1;
  endtask

  // One full service: grant edge, optional erase, plot, done, idle.
  task automatic service(input string tag, input logic [1:0] rq, input logic hold,
                         input int gi, input logic erase,
                         input logic [7:0] ox, input logic [6:0] oy,
                         input logic [7:0] nx, input logic [6:0] ny,
                         input logic [2:0] col);
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    int q;
    if (gi == 0) begin
      req0_x = nx; req0_y = ny; req0_colour = col;
    end else begin
      req1_x = nx; req1_y = ny; req1_colour = col;
    end
    req = rq;
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_grant"}, 32'(grant), (gi == 0) ? 1 : 2);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_load_we"}, 32'(writeEn), 0);
    chk({tag, "_load_x"}, 32'(vga_x), 0);
    if (!hold) req = 2'b00;
    @(posedge clock);
    #1;
    if (gi == 0) begin
      req0_x = 8'hA5; req0_y = 7'h33; req0_colour = ~col;
    end else begin
      req1_x = 8'h5A; req1_y = 7'h44; req1_colour = ~col;
    end
    for (int p = 0; p < (erase ? 32 : 16); p++) begin
      @(negedge clock);
      if (erase && p < 16) begin
        ex = ox + 8'(p % 4);
        ey = oy + 7'(p / 4);
        ec = 3'b000;
      end else begin
        q = erase ? p - 16 : p;
        ex = nx + 8'(q % 4);
        ey = ny + 7'(q / 4);
        ec = col;
      end
      chk({tag, "_we"}, 32'(writeEn), 1);
      chk({tag, "_x"}, 32'(vga_x), 32'(ex));
      chk({tag, "_y"}, 32'(vga_y), 32'(ey));
      chk({tag, "_col"}, 32'(vga_colour), 32'(ec));
      chk({tag, "_gnt_hold"}, 32'(grant), (gi == 0) ? 1 : 2);
    end
    @(negedge clock);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_done_we"}, 32'(writeEn), 0);
    chk({tag, "_done_x"}, 32'(vga_x), 0);
    chk({tag, "_done_gnt"}, 32'(grant), (gi == 0) ? 1 : 2);
    @(negedge clock);
    chk({tag, "_idle_done"}, 32'(done), 0);
    chk({tag, "_idle_busy"}, 32'(busy), 0);
    chk({tag, "_idle_gnt"}, 32'(grant), 0);
  endtask

  initial begin
    #2;
    check_quiet("por");
    do_reset();

    service("plot0", 2'b01, 1'b0, 0, 1'b0, 8'd0, 7'd0, 8'd10, 7'd20, 3'b100);
    service("erase0", 2'b01, 1'b0, 0, 1'b1, 8'd10, 7'd20, 8'd11, 7'd20, 3'b100);
    service("latch0", 2'b01, 1'b0, 0, 1'b1, 8'd11, 7'd20, 8'd30, 7'd40, 3'b010);
    service("wrap0", 2'b01, 1'b0, 0, 1'b1, 8'd30, 7'd40, 8'd254, 7'd126, 3'b110);
    service("first1", 2'b10, 1'b0, 1, 1'b0, 8'd0, 7'd0, 8'd5, 7'd6, 3'b111);
    service("again1", 2'b10, 1'b0, 1, 1'b1, 8'd5, 7'd6, 8'd7, 7'd8, 3'b001);
    service("again0", 2'b01, 1'b0, 0, 1'b1, 8'd254, 7'd126, 8'd2, 7'd3, 3'b011);

    do_reset();
    req0_x = 8'd50; req0_y = 7'd60; req0_colour = 3'b001;
    req1_x = 8'd100; req1_y = 7'd100; req1_colour = 3'b110;
    service("rr_a", 2'b11, 1'b1, 0, 1'b0, 8'd0, 7'd0, 8'd50, 7'd60, 3'b001);
    service("rr_b", 2'b11, 1'b1, 1, 1'b0, 8'd0, 7'd0, 8'd100, 7'd100, 3'b110);
    service("rr_c", 2'b11, 1'b1, 0, 1'b1, 8'd50, 7'd60, 8'd50, 7'd60, 3'b001);
    service("rr_d", 2'b11, 1'b1, 1, 1'b1, 8'd100, 7'd100, 8'd100, 7'd100, 3'b110);
    req = 2'b00;

    // Abort mid-plot at pixel 7, then confirm the next service skips erase.
    do_reset();
    req0_x = 8'd1; req0_y = 7'd2; req0_colour = 3'b011;
    req = 2'b01;
    @(posedge clock);
    @(negedge clock);
    chk("abort_grant", 32'(grant), 1);
    req = 2'b00;
    repeat (8) @(negedge clock);
    chk("abort_px7_we", 32'(writeEn), 1);
    chk("abort_px7_x", 32'(vga_x), 4);
    chk("abort_px7_y", 32'(vga_y), 3);
    #2;
    resetn = 1'b0;
    #1;
    chk("abort_we", 32'(writeEn), 0);
    chk("abort_gnt", 32'(grant), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_x", 32'(vga_x), 0);
    @(negedge clock);
    resetn = 1'b1;
    service("post_abort", 2'b01, 1'b0, 0, 1'b0, 8'd0, 7'd0, 8'd20, 7'd20, 3'b101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
